// File: rtl/servo_slew_sequencer_pkg.sv
// Shared constants, preset positions and FSM state type for the servo slew sequencer.
package servo_pkg;
  localparam int CW_W        = 17;
  localparam int PERIOD      = 100000;
  localparam int CW_MIN      = 5000;
  localparam int CW_MAX      = 10000;
  localparam int STEP        = 164;
  localparam int RESET_CW    = 9830;
  localparam int CW_LEFT     = 6555;
  localparam int CW_VERTICAL = 9830;

  typedef enum logic {IDLE, RAMP} seq_state_t;
endpackage

// File: rtl/servo_slew_sequencer_period_timer.sv
// Free-running PWM period counter with a registered end-of-period pulse.
module servo_period_timer #(
  parameter int CW_W   = servo_pkg::CW_W,
  parameter int PERIOD = servo_pkg::PERIOD
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);
  localparam logic [CW_W-1:0] LAST = CW_W'(PERIOD - 1);
  localparam logic [CW_W-1:0] PRE  = CW_W'(PERIOD - 2);

  logic [CW_W-1:0] count;

  // Tick is registered one count early so it is high exactly while count == PERIOD-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      period_tick <= 1'b0;
    end else begin
      count       <= (count == LAST) ? '0 : count + 1'b1;
      period_tick <= (count == PRE);
    end
  end
endmodule

// File: rtl/servo_slew_sequencer.sv
// Servo compare-word sequencer: clamps commanded targets and slews pwm_cw once per PWM period.
// Optional SERVO_SEQ_PRESET_EN adds preset_req/preset_sel shortcut targets (left / vertical).
module servo_slew_sequencer #(
  parameter int CW_W     = servo_pkg::CW_W,
  parameter int PERIOD   = servo_pkg::PERIOD,
  parameter int CW_MIN   = servo_pkg::CW_MIN,
  parameter int CW_MAX   = servo_pkg::CW_MAX,
  parameter int STEP     = servo_pkg::STEP,
  parameter int RESET_CW = servo_pkg::RESET_CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CW_W-1:0] cmd_target,
`ifdef SERVO_SEQ_PRESET_EN
  input  logic            preset_req,
  input  logic            preset_sel,
`endif
  output logic [CW_W-1:0] pwm_cw,
  output logic            period_tick,
  output logic            busy,
  output logic            at_target
);
  import servo_pkg::*;

  localparam logic [CW_W:0]   STEP_MAG = (CW_W+1)'(STEP);
  localparam logic [CW_W-1:0] STEP_CW  = CW_W'(STEP);

  function automatic logic [CW_W-1:0] clamp_cw(input logic [CW_W-1:0] v);
    if (v < CW_W'(CW_MIN)) return CW_W'(CW_MIN);
    if (v > CW_W'(CW_MAX)) return CW_W'(CW_MAX);
    return v;
  endfunction

  seq_state_t             state, state_n;
  logic [CW_W-1:0]        target, target_n, pwm_n;
  logic [CW_W-1:0]        req_target, clamped;
  logic                   req_valid;
  logic signed [CW_W:0]   diff;
  logic [CW_W:0]          mag;

  servo_period_timer #(.CW_W(CW_W), .PERIOD(PERIOD)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick)
  );

`ifdef SERVO_SEQ_PRESET_EN
  assign req_valid  = cmd_valid | preset_req;
  assign req_target = cmd_valid  ? cmd_target :
                      preset_sel ? CW_W'(CW_LEFT) : CW_W'(CW_VERTICAL);
`else
  assign req_valid  = cmd_valid;
  assign req_target = cmd_target;
`endif

  assign clamped = clamp_cw(req_target);
  assign diff    = $signed({1'b0, target}) - $signed({1'b0, pwm_cw});
  assign mag     = diff[CW_W] ? $unsigned(-diff) : $unsigned(diff);

  always_comb begin
    state_n  = state;
    target_n = target;
    pwm_n    = pwm_cw;
    case (state)
      IDLE: begin
        if (req_valid) begin
          target_n = clamped;
          if (clamped != pwm_cw) state_n = RAMP;
        end
      end
      RAMP: begin
        if (period_tick) begin
          if (mag <= STEP_MAG) begin
            pwm_n   = target;
            state_n = IDLE;
          end else if (diff[CW_W]) begin
            pwm_n = pwm_cw - STEP_CW;
          end else begin
            pwm_n = pwm_cw + STEP_CW;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state values so they match pwm_cw/target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= CW_W'(RESET_CW);
      pwm_cw    <= CW_W'(RESET_CW);
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      at_target <= 1'b1;
    end else begin
      state     <= state_n;
      target    <= target_n;
      pwm_cw    <= pwm_n;
      cmd_ready <= (state_n == IDLE);
      busy      <= (state_n == RAMP);
      at_target <= (pwm_n == target_n);
    end
  end
endmodule
